// File: rtl/config_frame_mem_shadowed.sv
// Double-buffered tile configuration memory: frames land in a shadow store, and a commit
// moves the whole shadow into the active store in one cycle, with readback and sticky errors.
module config_frame_mem_shadowed #(
    parameter int  NUM_FRAMES   = 4,
    parameter int  FRAME_BITS   = 32,
    parameter int  USED_LSB     = 12,
    parameter int  USED_BITS    = 20,
    parameter int  EN_PARITY    = 1,
    parameter int  REQUIRE_FULL = 0,
    localparam int AW           = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int CONFIG_BITS  = NUM_FRAMES * USED_BITS
) (
    input  logic                   CLK,
    input  logic                   resetn,
    input  logic [FRAME_BITS-1:0]  frame_data,
    input  logic [AW-1:0]          frame_addr,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    input  logic                   commit,
    output logic                   commit_done,
    output logic                   commit_err,
    input  logic                   rb_req,
    input  logic [AW-1:0]          rb_addr,
    output logic                   rb_valid,
    output logic [FRAME_BITS-1:0]  rb_data,
    input  logic                   err_clr,
    output logic                   parity_err,
    output logic                   addr_err,
    output logic [CONFIG_BITS-1:0] ConfigBits,
    output logic [CONFIG_BITS-1:0] ConfigBits_N,
    output logic [1:0]             dbgState
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COMMIT = 2'd1;
    localparam logic [1:0] RB     = 2'd2;

    generate
        if (USED_LSB + USED_BITS > FRAME_BITS) begin : g_width_check
            $error("stored field USED_LSB+USED_BITS exceeds FRAME_BITS");
        end
    endgenerate

    logic [1:0]             state;
    logic [CONFIG_BITS-1:0] shadow;
    logic [CONFIG_BITS-1:0] active;
    logic [NUM_FRAMES-1:0]  writtenMask;
    logic [AW-1:0]          rbAddrQ;
    logic [FRAME_BITS-1:0]  rbSel;
    logic writeFire, writeAddrOk, writeParityBad, writeOk;
    logic rbAddrOk, setParityErr, setAddrErr, commitReject;

    // Handshake: a frame moves on a rising edge where frame_valid and frame_ready are both 1;
    // the requester holds frame_valid/data/addr stable while frame_ready is 0.
    assign frame_ready    = (state == IDLE) & ~commit & ~rb_req;
    assign writeFire      = frame_valid & frame_ready;
    assign writeAddrOk    = {1'b0, frame_addr} < (AW+1)'(NUM_FRAMES);
    assign writeParityBad = (EN_PARITY != 0) && (^frame_data);
    assign writeOk        = writeFire & writeAddrOk & ~writeParityBad;
    assign rbAddrOk       = {1'b0, rbAddrQ} < (AW+1)'(NUM_FRAMES);
    assign commitReject   = (REQUIRE_FULL != 0) && !(&writtenMask);

    // An address error takes precedence over a parity error on the same write.
    assign setParityErr = writeFire & writeAddrOk & writeParityBad;
    assign setAddrErr   = (writeFire & ~writeAddrOk) | ((state == RB) & ~rbAddrOk);

    assign ConfigBits   = active;
    assign ConfigBits_N = ~active;
    assign dbgState     = state;

    always_comb begin
        rbSel = '0;
        for (int f = 0; f < NUM_FRAMES; f++) begin
            if (rbAddrQ == AW'(f)) begin
                rbSel[USED_LSB +: USED_BITS] = active[f*USED_BITS +: USED_BITS];
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            shadow      <= '0;
            active      <= '0;
            writtenMask <= '0;
            rbAddrQ     <= '0;
            rb_data     <= '0;
            commit_done <= 1'b0;
            commit_err  <= 1'b0;
            rb_valid    <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            commit_err  <= 1'b0;
            rb_valid    <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit) begin
                        if (commitReject) begin
                            commit_err <= 1'b1;
                        end else begin
                            state <= COMMIT;
                        end
                    end else if (rb_req) begin
                        rbAddrQ <= rb_addr;
                        state   <= RB;
                    end else if (writeOk) begin
                        for (int f = 0; f < NUM_FRAMES; f++) begin
                            if (frame_addr == AW'(f)) begin
                                shadow[f*USED_BITS +: USED_BITS] <= frame_data[USED_LSB +: USED_BITS];
                                writtenMask[f] <= 1'b1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    // Shadow is kept so later commits can carry incremental updates.
                    active      <= shadow;
                    writtenMask <= '0;
                    commit_done <= 1'b1;
                    state       <= IDLE;
                end
                RB: begin
                    rb_data  <= rbSel;
                    rb_valid <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flags: a new error in the same cycle as err_clr wins.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            parity_err <= setParityErr | (parity_err & ~err_clr);
            addr_err   <= setAddrErr | (addr_err & ~err_clr);
        end
    end

endmodule
